// File: rtl/cw_step_sequencer.sv
// Board test sequencer: assembles a wide control word from a narrow switch bank
// and advances the datapath with one-cycle step-enable pulses (single, burst, free-run).

module cw_step_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int CNTW = $clog2(CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [CNTW-1:0] cnt;

    // level is the debounced "pressed" state; cnt counts consecutive samples disagreeing with it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module cw_step_sequencer #(
    parameter int CW_WIDTH        = 40,
    parameter int CHUNK_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    localparam int NCHUNK = (CW_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH,
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   btn_load_n,
    input  logic                   btn_step_n,
    input  logic [1:0]             mode,
    input  logic [7:0]             burst_count,
    input  logic [CHUNK_WIDTH-1:0] sw_chunk,
    output logic [CW_WIDTH-1:0]    cw_out,
    output logic [IDXW-1:0]        chunk_idx,
    output logic                   cw_ready,
    output logic                   step_en,
    output logic [15:0]            step_count,
    output logic                   busy
);
    localparam int DIVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RUN_DIV - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, PULSE, BURST, RUN} state_t;

    state_t              state;
    logic [CW_WIDTH-1:0] staging;
    logic [CW_WIDTH-1:0] staging_nxt;
    logic [7:0]          remaining;
    logic [DIVW-1:0]     div_cnt;
    logic                load_ev;
    logic                step_ev;
    logic                load_done;
    logic                apply_word;

    cw_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clock(clock), .reset(reset), .btn_n(btn_load_n), .press(load_ev)
    );
    cw_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clock(clock), .reset(reset), .btn_n(btn_step_n), .press(step_ev)
    );

    // Bits past CW_WIDTH in the last chunk simply have no destination.
    always_comb begin
        staging_nxt = staging;
        if (load_ev) begin
            for (int i = 0; i < CW_WIDTH; i++) begin
                if ((i / CHUNK_WIDTH) == int'(chunk_idx)) staging_nxt[i] = sw_chunk[i % CHUNK_WIDTH];
            end
        end
    end

    assign load_done  = load_ev && (chunk_idx == LAST_IDX);
    assign apply_word = cw_ready || load_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            staging    <= '0;
            cw_out     <= '0;
            chunk_idx  <= '0;
            cw_ready   <= 1'b0;
            step_en    <= 1'b0;
            step_count <= '0;
            busy       <= 1'b0;
            remaining  <= '0;
            div_cnt    <= '0;
        end else begin
            step_en <= 1'b0;
            if (load_ev) begin
                staging   <= staging_nxt;
                chunk_idx <= load_done ? '0 : chunk_idx + 1'b1;
                if (load_done) cw_ready <= 1'b1;
            end
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (step_ev && mode != 2'b11) begin
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        // A load completing in the same cycle is applied by this step.
                        if (apply_word) begin
                            cw_out   <= staging_nxt;
                            cw_ready <= 1'b0;
                        end
                        case (mode)
                            2'b00: state <= PULSE;
                            2'b01: begin
                                remaining <= burst_count;
                                state     <= (burst_count == 8'd0) ? IDLE : BURST;
                            end
                            default: state <= RUN;
                        endcase
                    end
                end
                PULSE: begin
                    step_en    <= 1'b1;
                    step_count <= step_count + 16'd1;
                    state      <= IDLE;
                end
                BURST: begin
                    if (step_ev) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (div_cnt == '0) begin
                        step_en    <= 1'b1;
                        step_count <= step_count + 16'd1;
                        remaining  <= remaining - 8'd1;
                        div_cnt    <= DIV_LAST;
                        if (remaining == 8'd1) state <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (step_ev) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (div_cnt == '0) begin
                        step_en    <= 1'b1;
                        step_count <= step_count + 16'd1;
                        div_cnt    <= DIV_LAST;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cw_step_sequencer.sv
// Bench for cw_step_sequencer: scenario tasks plus a step_en monitor that pops
// expected pulse cycles and step_count values from a scoreboard queue.

module tb_cw_step_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_load_n = 1'b1;
    logic        btn_step_n = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  burst_count = 8'd0;
    logic [7:0]  sw_chunk = 8'd0;
    logic [19:0] cw_out;
    logic [1:0]  chunk_idx;
    logic        cw_ready;
    logic        step_en;
    logic [15:0] step_count;
    logic        busy;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_count = 16'd0;
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];

    cw_step_sequencer #(
        .CW_WIDTH(20), .CHUNK_WIDTH(8), .DEBOUNCE_CYCLES(4), .RUN_DIV(3)
    ) dut (
        .clock(clock), .reset(reset), .btn_load_n(btn_load_n), .btn_step_n(btn_step_n),
        .mode(mode), .burst_count(burst_count), .sw_chunk(sw_chunk),
        .cw_out(cw_out), .chunk_idx(chunk_idx), .cw_ready(cw_ready),
        .step_en(step_en), .step_count(step_count), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every step_en pulse must match the head of the expected queues.
    always @(negedge clock) begin
        if (!reset && step_en) begin
            checks++;
            if (exp_cyc_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step cyc=%0d step_count=%h", cyc, step_count);
            end else begin
                int          ec;
                logic [15:0] ev;
                ec = exp_cyc_q.pop_front();
                ev = exp_q.pop_front();
                if (cyc !== ec || step_count !== ev) begin
                    errors++;
                    $display("FAIL step_pulse got cyc=%0d count=%h expected cyc=%0d count=%h",
                             cyc, step_count, ec, ev);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_pulse(input int c);
        model_count = model_count + 16'd1;
        exp_cyc_q.push_back(c);
        exp_q.push_back(model_count);
    endtask

    task automatic press_begin(input bit is_step, output int t);
        @(posedge clock);
        #1;
        if (is_step) btn_step_n = 1'b0;
        else         btn_load_n = 1'b0;
        t = cyc;
    endtask

    task automatic press_end(input bit is_step, input int t, input int hold);
        wait_cyc(t + hold);
        if (is_step) btn_step_n = 1'b1;
        else         btn_load_n = 1'b1;
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_pulses=%0d expected 0", name, exp_cyc_q.size());
        end
        exp_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic check_busy(input string name, input logic expv);
        checks++;
        if (busy !== expv) begin
            errors++;
            $display("FAIL %s busy=%b expected %b cyc=%0d", name, busy, expv, cyc);
        end
    endtask

    task automatic check_count(input string name);
        checks++;
        if (step_count !== model_count) begin
            errors++;
            $display("FAIL %s step_count=%h expected %h", name, step_count, model_count);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (cw_out !== 20'h0 || chunk_idx !== 2'd0 || cw_ready !== 1'b0 ||
            step_en !== 1'b0 || step_count !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s cw_out=%h idx=%0d ready=%b step_en=%b count=%h busy=%b expected all 0",
                     name, cw_out, chunk_idx, cw_ready, step_en, step_count, busy);
        end
    endtask

    task automatic load_chunk(input logic [7:0] d, input logic [1:0] exp_idx, input logic exp_ready);
        int t;
        sw_chunk = d;
        press_begin(1'b0, t);
        press_end(1'b0, t, 4);
        wait_cyc(t + 14);
        checks++;
        if (chunk_idx !== exp_idx || cw_ready !== exp_ready || cw_out !== 20'h0) begin
            errors++;
            $display("FAIL load_%h idx=%0d ready=%b cw_out=%h expected idx=%0d ready=%b cw_out=0",
                     d, chunk_idx, cw_ready, cw_out, exp_idx, exp_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset_state");
        reset = 1'b0;
        wait_cyc(cyc + 3);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_load_and_single();
        int t;
        int e;
        mode = 2'b00;
        load_chunk(8'hA5, 2'd1, 1'b0);
        load_chunk(8'h3C, 2'd2, 1'b0);
        load_chunk(8'hF7, 2'd0, 1'b1);
        press_begin(1'b1, t);
        e = t + 6;
        push_pulse(e + 2);
        press_end(1'b1, t, 4);
        wait_cyc(e);
        checks++;
        if (cw_out !== 20'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pre cw_out=%h busy=%b expected 0 0", cw_out, busy);
        end
        wait_cyc(e + 1);
        checks++;
        if (cw_out !== 20'h73CA5 || cw_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_apply cw_out=%h ready=%b busy=%b expected 73ca5 0 1",
                     cw_out, cw_ready, busy);
        end
        wait_cyc(e + 3);
        check_busy("single_done", 1'b0);
        wait_cyc(e + 8);
        check_count("single_count");
        check_queue_empty("single_pulses");
    endtask

    task automatic test_debounce();
        int t;
        int e;
        press_begin(1'b1, t);
        press_end(1'b1, t, 3);
        wait_cyc(t + 16);
        check_busy("glitch_busy", 1'b0);
        check_count("glitch_count");
        press_begin(1'b1, t);
        e = t + 6;
        push_pulse(e + 2);
        press_end(1'b1, t, 4);
        wait_cyc(e);
        check_busy("event_not_early", 1'b0);
        wait_cyc(e + 1);
        check_busy("event_at_t6", 1'b1);
        checks++;
        if (cw_out !== 20'h73CA5) begin
            errors++;
            $display("FAIL cw_hold cw_out=%h expected 73ca5", cw_out);
        end
        wait_cyc(e + 10);
        check_queue_empty("debounce_pulses");
    endtask

    task automatic test_burst();
        int t;
        int e;
        mode = 2'b01;
        burst_count = 8'd4;
        press_begin(1'b1, t);
        e = t + 6;
        for (int k = 0; k < 4; k++) push_pulse(e + 2 + 3 * k);
        press_end(1'b1, t, 4);
        wait_cyc(e + 3);
        burst_count = 8'd1;
        mode = 2'b00;
        wait_cyc(e + 11);
        check_busy("burst_busy_last", 1'b1);
        wait_cyc(e + 12);
        check_busy("burst_busy_end", 1'b0);
        check_count("burst_count4");
        check_queue_empty("burst_pulses");
        mode = 2'b01;
        burst_count = 8'd0;
        press_begin(1'b1, t);
        e = t + 6;
        press_end(1'b1, t, 4);
        wait_cyc(e);
        check_busy("burst0_pre", 1'b0);
        wait_cyc(e + 1);
        check_busy("burst0_busy", 1'b1);
        wait_cyc(e + 2);
        check_busy("burst0_after", 1'b0);
        wait_cyc(e + 10);
        check_count("burst0_count");
        check_queue_empty("burst0_pulses");
    endtask

    task automatic test_run();
        int t;
        int t2;
        int e;
        int e2;
        mode = 2'b10;
        press_begin(1'b1, t);
        e = t + 6;
        for (int k = 0; k < 5; k++) push_pulse(e + 2 + 3 * k);
        press_end(1'b1, t, 4);
        wait_cyc(e + 5);
        mode = 2'b11;
        wait_cyc(t + 14);
        press_begin(1'b1, t2);
        e2 = t2 + 6;
        press_end(1'b1, t2, 4);
        wait_cyc(e2);
        check_busy("run_busy_at_abort", 1'b1);
        wait_cyc(e2 + 1);
        check_busy("run_abort_idle", 1'b0);
        wait_cyc(e2 + 12);
        check_count("run_count5");
        check_queue_empty("run_pulses");
        press_begin(1'b1, t);
        e = t + 6;
        press_end(1'b1, t, 4);
        wait_cyc(e + 1);
        check_busy("hold_mode_ignored", 1'b0);
        wait_cyc(e + 10);
        check_count("hold_mode_count");
        check_queue_empty("hold_mode_pulses");
    endtask

    task automatic test_wrap();
        int t;
        int e;
        @(posedge clock);
        #1;
        force dut.step_count = 16'hFFFE;
        @(negedge clock);
        release dut.step_count;
        model_count = 16'hFFFE;
        @(posedge clock);
        #1;
        check_count("wrap_preset");
        mode = 2'b01;
        burst_count = 8'd3;
        press_begin(1'b1, t);
        e = t + 6;
        for (int k = 0; k < 3; k++) push_pulse(e + 2 + 3 * k);
        press_end(1'b1, t, 4);
        wait_cyc(e + 12);
        checks++;
        if (step_count !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_final step_count=%h expected 0001", step_count);
        end
        check_queue_empty("wrap_pulses");
    endtask

    task automatic test_reset_mid_burst();
        int t;
        int e;
        mode = 2'b01;
        burst_count = 8'd10;
        press_begin(1'b1, t);
        e = t + 6;
        push_pulse(e + 2);
        push_pulse(e + 5);
        press_end(1'b1, t, 4);
        wait_cyc(e + 6);
        check_busy("mid_burst_busy", 1'b1);
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_burst");
        check_queue_empty("pre_reset_pulses");
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_count = 16'd0;
        wait_cyc(cyc + 20);
        check_idle_outputs("post_reset_quiet");
        check_queue_empty("post_reset_pulses");
    endtask

    initial begin
        test_reset();
        test_load_and_single();
        test_debounce();
        test_burst();
        test_run();
        test_wrap();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cw_step_sequencer.md
Name: cw_step_sequencer

Overview:
- Board-level test sequencer that drives a wide control word into the datapath under test from a narrow switch bank.
- Control word is assembled chunk-by-chunk from switches, then applied atomically.
- Datapath advancement uses one-cycle step-enable pulses (no gated clocks) in three modes: single-step, N-step burst, free-run.
- Replaces raw-button clocking; runs on the board 50 MHz clock.

Parameters:
CW_WIDTH, 40, control word width in bits (>=1).
CHUNK_WIDTH, 8, switch bits loaded per load press (>=1).
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level change (>=1).
RUN_DIV, 25000000, cycles between step pulses in burst/free-run (>=1).
Derived: NCHUNK = ceil(CW_WIDTH/CHUNK_WIDTH); IDXW = max(1, clog2(NCHUNK)).

Ports:
clock  input  1  system clock (CLOCK_50)
reset  input  1  asynchronous, active-high reset
btn_load_n  input  1  raw load button, active low, asynchronous to clock
btn_step_n  input  1  raw step button, active low, asynchronous to clock
mode  input  2  00 single, 01 burst, 10 free-run, 11 hold (steps disabled)
burst_count  input  8  pulses per burst
sw_chunk  input  CHUNK_WIDTH  switch data for current chunk
cw_out  output  CW_WIDTH  applied control word to datapath
chunk_idx  output  IDXW  index of next chunk to load
cw_ready  output  1  full staged word loaded, not yet applied
step_en  output  1  one-cycle datapath advance pulse
step_count  output  16  total step_en pulses issued, wraps
busy  output  1  sequencer in PULSE/BURST/RUN

Behaviour:
- Reset (async, active-high): cw_out=0, staging=0, chunk_idx=0, cw_ready=0, step_en=0, step_count=0, busy=0, FSM=IDLE, both debouncers=released, all counters=0.
- Debounce (per button): 2-FF synchroniser, then a counter of consecutive samples differing from the debounced level.
  - Counter clears on any sample equal to the debounced level.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips.
  - The press event is a 1-cycle pulse on the released->pressed flip; release produces no event.
  - Raw press held from cycle T gives the event in cycle T+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Load (on load event, any FSM state):
  - staging[idx*CHUNK_WIDTH +: CHUNK_WIDTH] <= sw_chunk; the last chunk is truncated to the remaining CW_WIDTH bits.
  - chunk_idx increments. On the last chunk, chunk_idx wraps to 0 and cw_ready<=1.
  - cw_out is never changed by load.
- Step FSM states: IDLE, PULSE, BURST, RUN. Let step event occur in cycle E.
  - IDLE + event, mode 11: ignored.
  - IDLE + event, other modes:
    - In E+1: if cw_ready, cw_out<=staging and cw_ready<=0; otherwise cw_out holds.
    - FSM enters PULSE (00), BURST with remaining=burst_count (01), or RUN (10); busy=1.
    - Mode 01 with burst_count=0: cw_out is still applied, no pulse, FSM returns to IDLE, busy high for exactly one cycle.
  - First step_en in E+2. Subsequent pulses (BURST/RUN) every RUN_DIV cycles: E+2+k*RUN_DIV.
  - PULSE: after its single pulse, returns to IDLE.
  - BURST: decrement remaining per pulse; after the pulse that makes remaining 0, return to IDLE.
  - RUN: continues until a step event, then returns to IDLE next cycle with no further pulse. A step event in BURST aborts the same way.
  - busy deasserts the cycle after the last step_en, or after the abort.
  - mode and burst_count are sampled only at the IDLE event; later changes are ignored until IDLE.
- step_count increments on every step_en cycle, 16-bit wrap (0xFFFF->0x0000). Cleared only by reset.
- Simultaneous load and step events in IDLE: the load writes staging first. If it completes the word, the same step applies the new word.
- Reset mid-burst/run: immediate return to reset values; no partial pulse.

Test Plan:
(Bench params: CW_WIDTH=20, CHUNK_WIDTH=8, DEBOUNCE_CYCLES=4, RUN_DIV=3.)
- Load presses with sw_chunk=0xA5, 0x3C, 0xF7 -> chunk_idx 1,2,0; cw_ready=1; cw_out stays 0; mode 00 step -> cw_out=0x73CA5, single step_en at E+2, step_count=1, cw_ready=0.
- Raw step low for 3 cycles then high -> no event, no step_en; held low from cycle T -> event exactly at T+6.
- mode 01, burst_count=4, step -> step_en at E+2,E+5,E+8,E+11; busy low at E+12; step_count +4; burst_count=0 -> busy one cycle, no step_en.
- mode 10 step, second step event after 5 pulses -> exactly 5 pulses, FSM IDLE, busy 0; changing mode to 11 mid-run has no effect.
- Preset step_count to 0xFFFE via 0xFFFE pulses (or force), burst of 3 -> count sequence 0xFFFF, 0x0000, 0x0001.
- Assert reset mid-burst (after 2 pulses) -> all outputs 0 in same cycle; after release no step_en until a new step event.
